// File: rtl/subneg_pkg.sv
// rtl/subneg_pkg.sv - shared types for the SUBNEG run/halt sequencer
package subneg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        CAUSE_STEP = 2'd0,
        CAUSE_REQ  = 2'd1,
        CAUSE_LOOP = 2'd2,
        CAUSE_BKPT = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/subneg_sat_counter.sv
// rtl/subneg_sat_counter.sv - saturating up-counter with synchronous clear
module subneg_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/subneg_run_ctrl.sv
// rtl/subneg_run_ctrl.sv - run/halt/step sequencer gating the SUBNEG core; SUBNEG_BREAKPOINT_EN adds a PC breakpoint
module subneg_run_ctrl
    import subneg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              step,
    input  logic              instr_start,
    input  logic              instr_done,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_next,
`ifdef SUBNEG_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
`endif
    output logic              core_en,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  instr_count
);

    run_state_t        r_state;
    run_state_t        w_next_state;
    halt_cause_t       r_cause;
    halt_cause_t       w_cause;
    logic [ADDR_W-1:0] r_start_addr;
    logic              r_halt_pend;
    logic              r_running;
    logic              r_halted;
    logic              w_active;
    logic              w_retire;
    logic              w_cnt_clr;
    logic              w_halt;
    logic              w_loop;
    logic              w_bkpt;
    logic              w_req;

    assign w_active = (r_state == RUN) || (r_state == STEP);
    assign w_retire = w_active && instr_done;

    // A jump to the instruction's own address is the program's halt idiom.
    assign w_loop = (pc_next == r_start_addr);
    assign w_req  = r_halt_pend || halt_req;
`ifdef SUBNEG_BREAKPOINT_EN
    assign w_bkpt = bp_valid && (pc_next == bp_addr);
`else
    assign w_bkpt = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_halt       = 1'b0;
        w_cause      = CAUSE_STEP;
        case (r_state)
            IDLE, HALTED: begin
                // halt_req beats a simultaneous start/step; IDLE entry also resets the count
                if (!halt_req) begin
                    if (start) begin
                        w_next_state = RUN;
                        w_cnt_clr    = (r_state == IDLE);
                    end else if (step) begin
                        w_next_state = STEP;
                        w_cnt_clr    = (r_state == IDLE);
                    end
                end
            end
            RUN, STEP: begin
                if (instr_done) begin
                    if (w_loop) begin
                        w_halt  = 1'b1;
                        w_cause = CAUSE_LOOP;
                    end else if (w_bkpt) begin
                        w_halt  = 1'b1;
                        w_cause = CAUSE_BKPT;
                    end else if (w_req) begin
                        w_halt  = 1'b1;
                        w_cause = CAUSE_REQ;
                    end else if (r_state == STEP) begin
                        w_halt  = 1'b1;
                        w_cause = CAUSE_STEP;
                    end
                    if (w_halt) begin
                        w_next_state = HALTED;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_cause      <= CAUSE_STEP;
            r_start_addr <= '0;
            r_halt_pend  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= (w_next_state == RUN) || (w_next_state == STEP);
            r_halted  <= (w_next_state == HALTED);
            if (w_halt) begin
                r_cause <= w_cause;
            end
            if (instr_start) begin
                r_start_addr <= pc;
            end
            if ((w_next_state == HALTED) && (r_state != HALTED)) begin
                r_halt_pend <= 1'b0;
            end else if (w_active && halt_req) begin
                r_halt_pend <= 1'b1;
            end
        end
    end

    subneg_sat_counter #(
        .WIDTH (CNT_W)
    ) u_instr_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_retire),
        .o_count (instr_count)
    );

    assign core_en    = w_active;
    assign running    = r_running;
    assign halted     = r_halted;
    assign halt_cause = r_cause;

endmodule

// File: tb/tb_subneg_run_ctrl.sv
// tb/tb_subneg_run_ctrl.sv - self-checking bench for subneg_run_ctrl with a four-phase core model
module tb_subneg_run_ctrl;
    import subneg_pkg::*;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 5;
    localparam int CNT_MAX = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic halt_req = 1'b0;
    logic step = 1'b0;
    logic instr_start, instr_done;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
`ifdef SUBNEG_BREAKPOINT_EN
    logic [ADDR_W-1:0] bp_addr = '0;
    logic bp_valid = 1'b0;
`endif
    logic core_en, running, halted;
    logic [1:0] halt_cause;
    logic [CNT_W-1:0] instr_count;

    logic [ADDR_W-1:0] prog [256];
    logic [1:0] c_phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subneg_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .step        (step),
        .instr_start (instr_start),
        .instr_done  (instr_done),
        .pc          (pc),
        .pc_next     (pc_next),
`ifdef SUBNEG_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
`endif
        .core_en     (core_en),
        .running     (running),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .instr_count (instr_count)
    );

    // Four-phase core: phase advances only while enabled, PC updates on the last phase.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_phase <= 2'd0;
            pc      <= '0;
        end else if (core_en) begin
            c_phase <= c_phase + 2'd1;
            if (c_phase == 2'd3) pc <= pc_next;
        end
    end
    assign instr_start = (c_phase == 2'd0);
    assign instr_done  = (c_phase == 2'd3);
    assign pc_next     = prog[pc];

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_linear;
        for (int i = 0; i < 256; i++) prog[i] = ADDR_W'(i + 1);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (core_en && instr_done) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({core_en, running, halted, halt_cause, instr_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {core_en, running, halted, halt_cause, instr_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_run_count;
        bit ok;
        do_reset();
        set_linear();
        pulse_start();
        checks++;
        if (core_en !== 1'b1) begin errors++; $display("FAIL start_core_en: got %b expected 1", core_en); end
        for (int i = 0; i < 3; i++) begin
            wait_done(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL run_done_timeout: got 0 expected 1"); end
            @(negedge clk);
        end
        checks++;
        if (instr_count !== 5'd3) begin errors++; $display("FAIL run_count: got %0d expected 3", instr_count); end
        checks++;
        if ({running, halted} !== 2'b10) begin errors++; $display("FAIL run_state: got %b expected 10", {running, halted}); end
    endtask

    task automatic test_loop;
        bit ok;
        logic [ADDR_W-1:0] last_pc;
        prog[8'h10] = 8'h10;
        last_pc = '0;
        for (int n = 0; n < 30 && !halted; n++) begin
            wait_done(ok);
            last_pc = pc;
            @(negedge clk);
        end
        checks++;
        if ({halted, core_en, running} !== 3'b100) begin errors++; $display("FAIL loop_halted: got %b expected 100", {halted, core_en, running}); end
        checks++;
        if (halt_cause !== CAUSE_LOOP) begin errors++; $display("FAIL loop_cause: got %0d expected 2", halt_cause); end
        checks++;
        if (last_pc !== 8'h10) begin errors++; $display("FAIL loop_pc: got %0h expected 10", last_pc); end
        checks++;
        if (instr_count !== 5'd17) begin errors++; $display("FAIL loop_count: got %0d expected 17", instr_count); end
    endtask

    task automatic test_halt_req;
        bit ok;
        do_reset();
        set_linear();
        pulse_start();
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        checks++;
        if ({core_en, halted} !== 2'b10) begin errors++; $display("FAIL req_mid_instr: got %b expected 10", {core_en, halted}); end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL req_done_timeout: got 0 expected 1"); end
        @(negedge clk);
        checks++;
        if ({halted, core_en} !== 2'b10) begin errors++; $display("FAIL req_halted: got %b expected 10", {halted, core_en}); end
        checks++;
        if (halt_cause !== CAUSE_REQ) begin errors++; $display("FAIL req_cause: got %0d expected 1", halt_cause); end
        checks++;
        if (instr_count !== 5'd1) begin errors++; $display("FAIL req_count: got %0d expected 1", instr_count); end
    endtask

    task automatic test_step;
        int n;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (core_en) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL step_cycles: got %0d expected 4", n); end
        checks++;
        if ({halted, halt_cause} !== {1'b1, CAUSE_STEP}) begin errors++; $display("FAIL step_halt: got %b expected 100", {halted, halt_cause}); end
        checks++;
        if (instr_count !== 5'd2) begin errors++; $display("FAIL step_count: got %0d expected 2", instr_count); end
    endtask

`ifdef SUBNEG_BREAKPOINT_EN
    task automatic test_bkpt;
        bit ok;
        do_reset();
        set_linear();
        bp_addr = 8'h20;
        bp_valid = 1'b1;
        pulse_start();
        for (int n = 0; n < 40 && !halted; n++) begin
            wait_done(ok);
            @(negedge clk);
        end
        checks++;
        if ({halted, halt_cause} !== {1'b1, CAUSE_BKPT}) begin errors++; $display("FAIL bkpt_halt: got %b expected 111", {halted, halt_cause}); end
        checks++;
        if (pc !== 8'h20) begin errors++; $display("FAIL bkpt_pc: got %0h expected 20", pc); end
        checks++;
        if (instr_count !== 5'd31) begin errors++; $display("FAIL bkpt_count_sat: got %0d expected 31", instr_count); end
        pulse_start();
        wait_done(ok);
        @(negedge clk);
        checks++;
        if ({running, halted, pc} !== {2'b10, 8'h21}) begin errors++; $display("FAIL bkpt_resume: got %0h expected 221", {running, halted, pc}); end
        bp_valid = 1'b0;
    endtask
`endif

    task automatic test_async_reset;
        do_reset();
        set_linear();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({core_en, running, halted, halt_cause, instr_count, c_phase} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %0h expected 0", {core_en, running, halted, halt_cause, instr_count, c_phase});
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt_req = 1'b0;
        checks++;
        if ({core_en, running, halted} !== 3'b000) begin errors++; $display("FAIL idle_start_halt: got %b expected 000", {core_en, running, halted}); end
    endtask

    task automatic test_random;
        bit m_run, m_halted, m_stepm, m_req, hit;
        int m_count, r;
        logic [1:0] m_cause, c;
        logic [ADDR_W-1:0] m_pc, nxt;
        do_reset();
        for (int i = 0; i < 256; i++)
            prog[i] = ($urandom_range(0, 9) == 0) ? ADDR_W'(i) : ADDR_W'($urandom_range(0, 31));
`ifdef SUBNEG_BREAKPOINT_EN
        bp_addr = ADDR_W'($urandom_range(0, 31));
        bp_valid = 1'b1;
`endif
        m_run = 0; m_halted = 0; m_stepm = 0; m_req = 0;
        m_count = 0; m_cause = CAUSE_STEP; m_pc = '0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            checks++;
            if ({core_en, running, halted} !== {m_run, m_run, m_halted}) begin
                errors++;
                $display("FAIL rnd_state cyc %0d: got %b expected %b", cyc, {core_en, running, halted}, {m_run, m_run, m_halted});
            end
            checks++;
            if (instr_count !== CNT_W'(m_count)) begin
                errors++;
                $display("FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, instr_count, m_count);
            end
            if (m_halted) begin
                checks++;
                if (halt_cause !== m_cause) begin
                    errors++;
                    $display("FAIL rnd_cause cyc %0d: got %0d expected %0d", cyc, halt_cause, m_cause);
                end
            end
            start = 1'b0; step = 1'b0; halt_req = 1'b0;
            if (m_run) begin
                halt_req = ($urandom_range(0, 15) == 0);
                start    = ($urandom_range(0, 15) == 0);
                step     = ($urandom_range(0, 15) == 0);
                if (instr_done) begin
                    nxt = prog[m_pc];
                    if (m_count < CNT_MAX) m_count++;
                    hit = 1'b1;
                    c = CAUSE_STEP;
                    if (nxt == m_pc) c = CAUSE_LOOP;
`ifdef SUBNEG_BREAKPOINT_EN
                    else if (bp_valid && nxt == bp_addr) c = CAUSE_BKPT;
`endif
                    else if (m_req || halt_req) c = CAUSE_REQ;
                    else if (m_stepm) c = CAUSE_STEP;
                    else hit = 1'b0;
                    m_pc = nxt;
                    if (hit) begin
                        m_run = 0; m_halted = 1; m_req = 0; m_cause = c;
                    end
                end else if (halt_req) begin
                    m_req = 1;
                end
            end else begin
                if ($urandom_range(0, 1) == 1) prog[m_pc] = ADDR_W'($urandom_range(0, 31));
                r = $urandom_range(0, 5);
                start    = (r == 0) || (r == 2);
                step     = (r == 1);
                halt_req = (r == 2) || (r == 3);
                if (!halt_req && (start || step)) begin
                    if (!m_halted) m_count = 0;
                    m_run = 1; m_halted = 0; m_stepm = step;
                end
            end
            @(negedge clk);
        end
        start = 1'b0; step = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = '0;
        @(negedge clk);
        test_reset();
        test_run_count();
        test_loop();
        test_halt_req();
        test_step();
`ifdef SUBNEG_BREAKPOINT_EN
        test_bkpt();
`endif
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
